// File: rtl/fwd_hazard_ctrl_if.sv
// Forwarding/hazard control bus between the ID/EX stage and fwd_hazard_ctrl.
// Carries ID operand info and branch redirect in; stall, bubble and forward selects out.
interface fwd_hazard_ctrl_if #(
   parameter int REG_AW = 5
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic [REG_AW-1:0] id_rd;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              branch_taken_ex;
   logic              stall_if_id;
   logic              bubble_ex;
   logic [1:0]        operand_a_forward_cntl;
   logic [1:0]        operand_b_forward_cntl;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rd,
      output id_reg_write, id_mem_read, branch_taken_ex,
      input  stall_if_id, bubble_ex,
      input  operand_a_forward_cntl, operand_b_forward_cntl
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rd,
      input  id_reg_write, id_mem_read, branch_taken_ex,
      output stall_if_id, bubble_ex,
      output operand_a_forward_cntl, operand_b_forward_cntl
   );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use hazard controller with EX/MEM rd shadow pipeline.
// Ports: clk, rst_n (async low), bus (slave modport); HAZARD_PERF_CNT_EN adds stall_count/fwd_count.
module fwd_hazard_ctrl #(
   parameter int REG_AW   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic                clk,
   input  logic                rst_n,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0]         stall_count,
   output logic [31:0]         fwd_count,
`endif
   fwd_hazard_ctrl_if.slave    bus
);

   logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
   logic              ex_wr_q, ex_wr_d;
   logic              ex_ld_q, ex_ld_d;
   logic [REG_AW-1:0] mem_rd_q;
   logic              mem_wr_q;
   logic [1:0]        fwd_a_q, fwd_a_d;
   logic [1:0]        fwd_b_q, fwd_b_d;
   logic              load_use;
   logic              stall;
   logic              bubble;
   logic              kill;

   // x0 never carries a value worth forwarding.
   function automatic logic real_reg(input logic [REG_AW-1:0] r);
      return (r != '0) && (int'(r) < NUM_REGS);
   endfunction

   // Current EX occupant lands in MEM next cycle, current MEM in WB.
   // A load in EX has no data yet at MEM, so it never yields 01.
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
      logic [1:0] s;
      s = 2'b00;
      if (ex_wr_q && !ex_ld_q && real_reg(ex_rd_q) && ex_rd_q == src)
         s = 2'b01;
      else if (mem_wr_q && real_reg(mem_rd_q) && mem_rd_q == src)
         s = 2'b10;
      return s;
   endfunction

   always_comb begin
      load_use = bus.id_valid & ex_ld_q & ex_wr_q & real_reg(ex_rd_q)
               & ((ex_rd_q == bus.id_rs1) | (ex_rd_q == bus.id_rs2));
      stall    = load_use & ~bus.branch_taken_ex;
      bubble   = load_use | bus.branch_taken_ex;
      kill     = bubble | ~bus.id_valid;
      ex_rd_d  = bus.id_rd;
      ex_wr_d  = bus.id_reg_write;
      ex_ld_d  = bus.id_mem_read;
      fwd_a_d  = fwd_sel(bus.id_rs1);
      fwd_b_d  = fwd_sel(bus.id_rs2);
      if (kill) begin
         ex_rd_d = '0;
         ex_wr_d = 1'b0;
         ex_ld_d = 1'b0;
         fwd_a_d = 2'b00;
         fwd_b_d = 2'b00;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_rd_q  <= '0;
         ex_wr_q  <= 1'b0;
         ex_ld_q  <= 1'b0;
         mem_rd_q <= '0;
         mem_wr_q <= 1'b0;
         fwd_a_q  <= 2'b00;
         fwd_b_q  <= 2'b00;
      end else begin
         mem_rd_q <= ex_rd_q;
         mem_wr_q <= ex_wr_q;
         ex_rd_q  <= ex_rd_d;
         ex_wr_q  <= ex_wr_d;
         ex_ld_q  <= ex_ld_d;
         fwd_a_q  <= fwd_a_d;
         fwd_b_q  <= fwd_b_d;
      end
   end

   assign bus.stall_if_id            = stall;
   assign bus.bubble_ex              = bubble;
   assign bus.operand_a_forward_cntl = fwd_a_q;
   assign bus.operand_b_forward_cntl = fwd_b_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] fwd_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         if (stall && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if ((fwd_a_q != 2'b00 || fwd_b_q != 2'b00)
             && fwd_cnt_q != 32'hFFFF_FFFF)
            fwd_cnt_q <= fwd_cnt_q + 32'd1;
      end
   end

   assign stall_count = stall_cnt_q;
   assign fwd_count   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Randomized and directed bench for fwd_hazard_ctrl against an instruction-level model.
// Prints one summary line with the number of comparisons and failures.
module tb_fwd_hazard_ctrl;

   logic clk;
   logic rst_n;
   int   n_run;
   int   n_fail;

   fwd_hazard_ctrl_if #(.REG_AW(5)) bus ();

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_count;
   logic [31:0] fwd_count;
   longint      m_scnt;
   longint      m_fcnt;
`endif

   fwd_hazard_ctrl #(.REG_AW(5), .NUM_REGS(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef HAZARD_PERF_CNT_EN
      .stall_count (stall_count),
      .fwd_count   (fwd_count),
`endif
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: the instruction occupying each later stage.
   typedef struct {
      int rd;
      bit wr;
      bit ld;
   } instr_t;

   instr_t in_ex;
   instr_t in_mem;
   int     m_a;
   int     m_b;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int producer_sel(input int src);
      if (in_ex.wr && !in_ex.ld && in_ex.rd != 0 && in_ex.rd == src)
         return 1;
      if (in_mem.wr && in_mem.rd != 0 && in_mem.rd == src)
         return 2;
      return 0;
   endfunction

   task automatic model_reset();
      in_ex  = '{0, 0, 0};
      in_mem = '{0, 0, 0};
      m_a    = 0;
      m_b    = 0;
`ifdef HAZARD_PERF_CNT_EN
      m_scnt = 0;
      m_fcnt = 0;
`endif
   endtask

   task automatic step(input bit v, input int rs1, input int rs2,
                       input int rd, input bit rw, input bit ld,
                       input bit br);
      bit lu;
      bit e_stall;
      bit e_bub;
      int na;
      int nb;
      instr_t nex;
      bus.id_valid        = v;
      bus.id_rs1          = 5'(rs1);
      bus.id_rs2          = 5'(rs2);
      bus.id_rd           = 5'(rd);
      bus.id_reg_write    = rw;
      bus.id_mem_read     = ld;
      bus.branch_taken_ex = br;
      #1;
      lu = v && in_ex.ld && in_ex.wr && in_ex.rd != 0
           && (in_ex.rd == rs1 || in_ex.rd == rs2);
      e_stall = lu && !br;
      e_bub   = lu || br;
      chk("stall", bus.stall_if_id, e_stall);
      chk("bubble", bus.bubble_ex, e_bub);
      if (e_bub || !v) begin
         nex = '{0, 0, 0};
         na  = 0;
         nb  = 0;
      end else begin
         nex = '{rd, rw, ld};
         na  = producer_sel(rs1);
         nb  = producer_sel(rs2);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (e_stall && m_scnt < 64'hFFFF_FFFF) m_scnt++;
      if ((m_a != 0 || m_b != 0) && m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
`endif
      @(posedge clk);
      #1;
      in_mem = in_ex;
      in_ex  = nex;
      m_a    = na;
      m_b    = nb;
      chk("fwd_a", bus.operand_a_forward_cntl, m_a);
      chk("fwd_b", bus.operand_b_forward_cntl, m_b);
`ifdef HAZARD_PERF_CNT_EN
      chk("stall_count", stall_count, m_scnt);
      chk("fwd_count", fwd_count, m_fcnt);
`endif
   endtask

   task automatic nop();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      n_run  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      bus.id_valid        = 1'b0;
      bus.id_rs1          = '0;
      bus.id_rs2          = '0;
      bus.id_rd           = '0;
      bus.id_reg_write    = 1'b0;
      bus.id_mem_read     = 1'b0;
      bus.branch_taken_ex = 1'b0;
      model_reset();
      #12;
      chk("rst_stall", bus.stall_if_id, 0);
      chk("rst_bubble", bus.bubble_ex, 0);
      chk("rst_a", bus.operand_a_forward_cntl, 0);
      chk("rst_b", bus.operand_b_forward_cntl, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // ALU back-to-back
      step(1, 1, 2, 5, 1, 0, 0);
      step(1, 5, 0, 9, 1, 0, 0);
      chk("alu_a", bus.operand_a_forward_cntl, 1);
      chk("alu_b", bus.operand_b_forward_cntl, 0);
      nop(); nop();

      // Distance-2
      step(1, 0, 0, 7, 1, 0, 0);
      step(1, 2, 3, 1, 1, 0, 0);
      step(1, 0, 7, 6, 1, 0, 0);
      chk("dist2_b", bus.operand_b_forward_cntl, 2);
      nop(); nop();

      // Load-use: consumer held for one cycle
      step(1, 0, 0, 3, 1, 1, 0);
      step(1, 3, 0, 8, 1, 0, 0);
      chk("lu_a_killed", bus.operand_a_forward_cntl, 0);
      step(1, 3, 0, 8, 1, 0, 0);
      chk("lu_a_wb", bus.operand_a_forward_cntl, 2);
      nop(); nop();

      // Priority MEM over WB
      step(1, 0, 0, 4, 1, 0, 0);
      step(1, 0, 0, 4, 1, 0, 0);
      step(1, 4, 4, 0, 0, 0, 0);
      chk("prio_a", bus.operand_a_forward_cntl, 1);
      chk("prio_b", bus.operand_b_forward_cntl, 1);
      nop(); nop();

      // x0 producer
      step(1, 0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 2, 1, 0, 0);
      chk("x0_a", bus.operand_a_forward_cntl, 0);
      nop(); nop();

      // Branch coincident with load-use
      step(1, 0, 0, 3, 1, 1, 0);
      step(1, 3, 0, 8, 1, 0, 1);
      chk("br_a", bus.operand_a_forward_cntl, 0);
      nop(); nop();

      // Reset during a pending load-use
      step(1, 0, 0, 3, 1, 1, 0);
      bus.id_valid        = 1'b1;
      bus.id_rs1          = 5'd3;
      bus.id_rd           = 5'd8;
      bus.id_reg_write    = 1'b1;
      bus.id_mem_read     = 1'b0;
      bus.branch_taken_ex = 1'b0;
      #1;
      chk("pre_rst_stall", bus.stall_if_id, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_stall", bus.stall_if_id, 0);
      chk("mid_rst_bubble", bus.bubble_ex, 0);
      chk("mid_rst_a", bus.operand_a_forward_cntl, 0);
      chk("mid_rst_b", bus.operand_b_forward_cntl, 0);
`ifdef HAZARD_PERF_CNT_EN
      chk("mid_rst_scnt", stall_count, 0);
      chk("mid_rst_fcnt", fwd_count, 0);
`endif
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1, 3, 8, 2, 1, 0, 0);
      chk("post_rst_a", bus.operand_a_forward_cntl, 0);
      chk("post_rst_b", bus.operand_b_forward_cntl, 0);

      // Randomized traffic over a small register set
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(7) != 0),
              int'($urandom_range(7)), int'($urandom_range(7)),
              int'($urandom_range(7)),
              1'($urandom_range(1)), 1'($urandom_range(3) == 0),
              ($urandom_range(9) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Produces the operand A/B forwarding selects consumed by the execute-stage forwarding muxes.
- Detects load-use hazards and issues the matching stall and bubble controls.
- Keeps its own shadow pipeline of destination-register info for the instructions in EX and MEM, advancing in lockstep with the core pipeline.
- Sits beside the ID/EX register and drives the IF/ID hold, the ID/EX bubble and the registered forward selects.

Parameters:
REG_AW, 5, register address width
NUM_REGS, 32, architectural registers; register 0 is hardwired zero, never forwarded

Ports:
clk  input  1  pipeline clock
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID stage holds a real instruction
id_rs1  input  REG_AW  ID source 1 address
id_rs2  input  REG_AW  ID source 2 address
id_rd  input  REG_AW  ID destination address
id_reg_write  input  1  ID instruction writes rd
id_mem_read  input  1  ID instruction is a load
branch_taken_ex  input  1  redirect resolved in EX this cycle; squash ID and the next EX entry
stall_if_id  output  1  hold PC and IF/ID this cycle
bubble_ex  output  1  load NOP into ID/EX this cycle
operand_a_forward_cntl  output  2  registered: 00 regfile, 01 MEM data, 10 WB data
operand_b_forward_cntl  output  2  registered: same encoding for operand B

Behaviour:
- Shadow state, all reset to 0 by async reset:
  - ex_rd, ex_wr, ex_ld: the instruction now in EX.
  - mem_rd, mem_wr: the instruction now in MEM.
- Hazard detect, combinational in the current cycle:
  - load_use = id_valid & ex_ld & ex_wr & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
  - stall_if_id = load_use & ~branch_taken_ex.
  - bubble_ex = load_use | branch_taken_ex.
- Shadow advance on every rising clk; there is no global enable:
  - mem_rd <= ex_rd and mem_wr <= ex_wr, always. The EX occupant always moves forward.
  - If bubble_ex or ~id_valid: ex_rd <= 0, ex_wr <= 0, ex_ld <= 0.
  - Otherwise: ex_rd <= id_rd, ex_wr <= id_reg_write, ex_ld <= id_mem_read.
- Forward select, registered so it is valid during the ID instruction's EX cycle:
  - For src = id_rs1 (A) and id_rs2 (B), evaluated against the shadows that will sit in MEM (current ex_*) and WB (current mem_*) next cycle.
  - Select 01 if ex_wr & ~ex_ld & ex_rd != 0 & ex_rd == src.
  - Else 10 if mem_wr & mem_rd != 0 & mem_rd == src.
  - Else 00.
  - MEM has priority over WB when both match (the youngest producer wins).
  - If bubble_ex or ~id_valid: both selects <= 00.
- Latency:
  - Forward selects follow ID inputs by exactly 1 clk.
  - Stall and bubble are same-cycle combinational.
- Load-use sequence:
  - Cycle t: stall=1, bubble=1.
  - Cycle t+1: the load is in MEM shadow, stall=0, and the held instruction gets select 10 at t+2.
  - A load never yields 01.
- Simultaneous events:
  - branch_taken_ex with load_use: no stall, and bubble is asserted.
  - Both sources matching the same producer: both selects are set identically.
  - rs1 == rs2 == 0: always 00.
  - rd == 0 producers are ignored at every stage.
- Reset mid-operation: all shadows and selects clear immediately. With all shadows cleared, stall_if_id and bubble_ex go 0 while rst_n is low (the branch_taken_ex term of bubble_ex still follows its input). The first post-reset ID instruction sees no hazards.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, add outputs:
  - stall_count[31:0]: increments on each cycle with stall_if_id=1.
  - fwd_count[31:0]: increments once per cycle in which either registered select goes non-zero.
  - Both are cleared by rst_n and saturate at 32'hFFFFFFFF.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- ALU back-to-back: add x5 in ID at t (rd=5, reg_write=1), then sub with rs1=5 in ID at t+1 -> at t+2 operand_a_forward_cntl=01, B=00, no stall.
- Distance-2: producer rd=7, one unrelated instruction, then consumer rs2=7 -> B=10 in the consumer's EX cycle.
- Load-use: load rd=3 (mem_read=1), then consumer rs1=3 -> stall_if_id=1 and bubble_ex=1 for exactly 1 cycle, then A=10 in the consumer's EX; never 01.
- Priority: rd=4 at t and rd=4 at t+1, consumer rs1=4, rs2=4 at t+2 -> A=01, B=01 (the MEM producer wins).
- x0 and flush: producer rd=0 followed by consumer rs1=0 -> 00. branch_taken_ex coincident with load_use -> stall=0, bubble=1, and the next selects are 00.
- Reset mid-stream: assert rst_n=0 during a pending load-use -> all outputs 0 within the same cycle. After release, an unrelated consumer sees 00. With HAZARD_PERF_CNT_EN, counters read 0.
